control_sequencer: RTL and testbench

//  Instruction register + T-state sequencer for the SAP-U core. Latches the instruction word the RAM

---
 rtl/sapu_pkg.sv | 35 +++
 rtl/control_sequencer_if.sv | 25 ++
 rtl/tstate_ring.sv | 14 +
 rtl/control_sequencer.sv | 86 ++++++++
 tb/tb_control_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/sapu_pkg.sv
// sapu_pkg: shared SAP-U opcodes, one-hot T-state codes and control-word bit indices
package sapu_pkg;
    localparam int DATA_W = 8;
    localparam int NUM_T  = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [NUM_T-1:0] T1 = 6'b000001;
    localparam logic [NUM_T-1:0] T2 = 6'b000010;
    localparam logic [NUM_T-1:0] T3 = 6'b000100;
    localparam logic [NUM_T-1:0] T4 = 6'b001000;
    localparam logic [NUM_T-1:0] T5 = 6'b010000;
    localparam logic [NUM_T-1:0] T6 = 6'b100000;

    // Control-word layout, also used by the top-level bus mux
    localparam int CW_PC_OUT    = 0;
    localparam int CW_PC_INC    = 1;
    localparam int CW_PC_LOAD   = 2;
    localparam int CW_LOAD_ADDR = 3;
    localparam int CW_OE        = 4;
    localparam int CW_LOAD_IR   = 5;
    localparam int CW_IR_OUT    = 6;
    localparam int CW_LOAD_A    = 7;
    localparam int CW_A_OUT     = 8;
    localparam int CW_LOAD_B    = 9;
    localparam int CW_ALU_OUT   = 10;
    localparam int CW_SUB       = 11;
    localparam int CW_LOAD_OUT  = 12;
    localparam int CW_W         = 13;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bus input, prog mode and control-word outputs of the sequencer
interface control_sequencer_if;
    import sapu_pkg::*;
    logic              prog_mode;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] ir_bus_out;
    logic [3:0]        opcode;
    logic [NUM_T-1:0]  tstate;
    logic pc_out, pc_inc, pc_load, load_addr_reg, output_enable, load_ir, ir_out;
    logic load_a, a_out, load_b, alu_out, sub, load_out, halt;

    modport master (
        input  prog_mode, bus_in,
        output ir_bus_out, opcode, tstate, pc_out, pc_inc, pc_load, load_addr_reg,
               output_enable, load_ir, ir_out, load_a, a_out, load_b, alu_out, sub,
               load_out, halt
    );

    modport slave (
        output prog_mode, bus_in,
        input  ir_bus_out, opcode, tstate, pc_out, pc_inc, pc_load, load_addr_reg,
               output_enable, load_ir, ir_out, load_a, a_out, load_b, alu_out, sub,
               load_out, halt
    );
endinterface

// File: rtl/tstate_ring.sv
// tstate_ring: one-hot T1..T6 ring counter with hold, clear-to-T1 and illegal-code recovery
module tstate_ring
    import sapu_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             hold,
    input  logic             clear,
    output logic [NUM_T-1:0] t
);
    // Rotate one position per cycle; reset, clear or a non-one-hot code restart at T1
    always_ff @(posedge clk)
        t <= (!clr_n || clear || !$onehot(t)) ? T1 : hold ? t : {t[NUM_T-2:0], t[NUM_T-1]};
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-U instruction register, T-state sequencer and control-word decode.
// Define SAPU_JMP_EN to decode opcode 4'h3 as JMP; otherwise it is a NOP and pc_load stays 0.
module control_sequencer
    import sapu_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    control_sequencer_if.master bus
);
    logic [DATA_W-1:0] ir;
    logic              halt;
    logic [NUM_T-1:0]  t;
    logic [CW_W-1:0]   cw;
    logic [3:0]        op;

    assign op = ir[DATA_W-1 -: 4];

    // Halt freezes the ring at T4 and takes priority over programming mode
    tstate_ring u_ring (
        .clk   (clk),
        .clr_n (clr_n),
        .hold  (halt),
        .clear (bus.prog_mode && !halt),
        .t     (t)
    );

    // IR captures the fetched word at the end of T3; a fetched HLT raises halt on T4 entry
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            ir   <= '0;
            halt <= 1'b0;
        end else begin
            if (cw[CW_LOAD_IR]) ir <= bus.bus_in;
            if (cw[CW_LOAD_IR] && bus.bus_in[DATA_W-1 -: 4] == OP_HLT) halt <= 1'b1;
        end
    end

    // Decode {opcode, tstate}; programming mode and halt silence every control
    always_comb begin
        cw = '0;
        if (!bus.prog_mode && !halt) begin
            case (t)
                T1: begin cw[CW_PC_OUT] = 1'b1; cw[CW_LOAD_ADDR] = 1'b1; end
                T2: cw[CW_PC_INC] = 1'b1;
                T3: begin cw[CW_OE] = 1'b1; cw[CW_LOAD_IR] = 1'b1; end
                T4: case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin cw[CW_IR_OUT] = 1'b1; cw[CW_LOAD_ADDR] = 1'b1; end
`ifdef SAPU_JMP_EN
                    OP_JMP: begin cw[CW_IR_OUT] = 1'b1; cw[CW_PC_LOAD] = 1'b1; end
`endif
                    OP_OUT: begin cw[CW_A_OUT] = 1'b1; cw[CW_LOAD_OUT] = 1'b1; end
                    default: ;
                endcase
                T5: case (op)
                    OP_LDA: begin cw[CW_OE] = 1'b1; cw[CW_LOAD_A] = 1'b1; end
                    OP_ADD, OP_SUB: begin cw[CW_OE] = 1'b1; cw[CW_LOAD_B] = 1'b1; end
                    default: ;
                endcase
                T6: begin
                    cw[CW_ALU_OUT] = op == OP_ADD || op == OP_SUB;
                    cw[CW_LOAD_A]  = op == OP_ADD || op == OP_SUB;
                    cw[CW_SUB]     = op == OP_SUB;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_out        = cw[CW_PC_OUT];
    assign bus.pc_inc        = cw[CW_PC_INC];
    assign bus.pc_load       = cw[CW_PC_LOAD];
    assign bus.load_addr_reg = cw[CW_LOAD_ADDR];
    assign bus.output_enable = cw[CW_OE];
    assign bus.load_ir       = cw[CW_LOAD_IR];
    assign bus.ir_out        = cw[CW_IR_OUT];
    assign bus.load_a        = cw[CW_LOAD_A];
    assign bus.a_out         = cw[CW_A_OUT];
    assign bus.load_b        = cw[CW_LOAD_B];
    assign bus.alu_out       = cw[CW_ALU_OUT];
    assign bus.sub           = cw[CW_SUB];
    assign bus.load_out      = cw[CW_LOAD_OUT];
    assign bus.halt          = halt;
    assign bus.tstate        = t;
    assign bus.opcode        = op;
    assign bus.ir_bus_out    = cw[CW_IR_OUT] ? {{(DATA_W-4){1'b0}}, ir[3:0]} : '0;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench for control_sequencer (honours SAPU_JMP_EN)
module tb_control_sequencer;
    // Control bits packed in port-list order, pc_out as MSB
    localparam logic [12:0] PCO = 13'h1000, PCI = 13'h0800, PCL = 13'h0400, LAR = 13'h0200;
    localparam logic [12:0] OE  = 13'h0100, LIR = 13'h0080, IRO = 13'h0040, LA  = 13'h0020;
    localparam logic [12:0] AO  = 13'h0010, LB  = 13'h0008, ALU = 13'h0004, SB  = 13'h0002;
    localparam logic [12:0] LO  = 13'h0001;

    typedef struct packed {
        logic [5:0]  t;
        logic [7:0]  irb;
        logic [3:0]  op;
        logic [12:0] cw;
        logic        h;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    int         m_t = 0;
    logic [7:0] m_ir = 8'h00;
    logic       m_halt = 1'b0;
    logic       m_valid = 1'b0;

    control_sequencer_if sif ();

    control_sequencer dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] exp_cw(input int t, input logic [3:0] op, input logic p, input logic h);
        if (p || h) return '0;
        case (t)
            0: return PCO | LAR;
            1: return PCI;
            2: return OE | LIR;
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) return IRO | LAR;
`ifdef SAPU_JMP_EN
                if (op == 4'h3) return IRO | PCL;
`endif
                if (op == 4'hE) return AO | LO;
                return '0;
            end
            4: begin
                if (op == 4'h0) return OE | LA;
                if (op == 4'h1 || op == 4'h2) return OE | LB;
                return '0;
            end
            5: begin
                if (op == 4'h1) return ALU | LA;
                if (op == 4'h2) return ALU | LA | SB;
                return '0;
            end
            default: return '0;
        endcase
    endfunction

    task automatic cyc(input logic c, input logic p, input logic [7:0] b);
        exp_t e;
        clr_n = c;
        sif.prog_mode = p;
        sif.bus_in = b;
        if (m_valid) begin
            e.t   = 6'b1 << m_t;
            e.op  = m_ir[7:4];
            e.cw  = exp_cw(m_t, m_ir[7:4], p, m_halt);
            e.irb = (e.cw & IRO) != 0 ? {4'h0, m_ir[3:0]} : 8'h00;
            e.h   = m_halt;
            q.push_back(e);
        end
        @(posedge clk);
        if (!c) begin
            m_t = 0; m_ir = 8'h00; m_halt = 1'b0; m_valid = 1'b1;
        end else if (m_valid && !m_halt) begin
            if (p) m_t = 0;
            else begin
                if (m_t == 2) begin
                    m_ir = b;
                    if (b[7:4] == 4'hF) m_halt = 1'b1;
                end
                m_t = m_t == 5 ? 0 : m_t + 1;
            end
        end
        #1;
    endtask

    task automatic run_instr(input logic [7:0] b);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, b);
    endtask

    // Compare DUT outputs against queued expectations mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("tstate", {10'h0, sif.tstate}, {10'h0, e.t});
            check("ir_bus_out", {8'h0, sif.ir_bus_out}, {8'h0, e.irb});
            check("opcode", {12'h0, sif.opcode}, {12'h0, e.op});
            check("controls", {3'h0, sif.pc_out, sif.pc_inc, sif.pc_load, sif.load_addr_reg,
                               sif.output_enable, sif.load_ir, sif.ir_out, sif.load_a, sif.a_out,
                               sif.load_b, sif.alu_out, sif.sub, sif.load_out}, {3'h0, e.cw});
            check("halt", {15'h0, sif.halt}, {15'h0, e.h});
        end
    end

    initial begin
        sif.prog_mode = 1'b0;
        sif.bus_in = 8'h00;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 8'h00);
        run_instr(8'h09);
        run_instr(8'h2C);
        run_instr(8'h1A);
        run_instr(8'hE0);
        run_instr(8'h50);
        run_instr(8'h37);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'h05);
        cyc(1'b1, 1'b1, 8'h05);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 8'h00);
        run_instr(8'h11);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'h2C);
        cyc(1'b0, 1'b0, 8'h00);
        run_instr(8'h09);
        for (int k = 0; k < 60; k++) begin
            logic [7:0] b;
            b = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0, b);
        end
        cyc(1'b0, 1'b0, 8'h00);
        run_instr(8'hF0);
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 8'h2C);
        cyc(1'b0, 1'b0, 8'h00);
        run_instr(8'h2C);
        cyc(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        if (q.size() != 0) check("queue_drain", 16'(q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
